// File: rtl/exe_ctrl_stage_if.sv
// ---------------------------------------------------------------------------
// exe_ctrl_stage_if
// Bundles every non-clock signal of the execute/memory sequencing stage.
//   slave  : the stage itself (consumes the control word and ALU/memory
//            responses, drives ALU command, memory request, writeback,
//            branch and status)
//   master : the surrounding pipeline / memory model
// Signals:
//   ctrl_in[9:0]  {S, B, EXE_CMD[3:0], MEM_W_EN, MEM_R_EN, -, WB_EN}
//   ctrl_valid, dest_in, store_data, flush      upstream instruction
//   alu_result, alu_flags                       ALU response
//   ex_exe_cmd, stall                           ALU command / front-end hold
//   mem_req, mem_we, mem_addr, mem_wdata        memory request
//   mem_ack, mem_rdata                          memory response
//   wb_en, wb_dest, wb_value                    register-file write port
//   branch_taken, status, mem_err               branch pulse, NZCV, timeout
// ---------------------------------------------------------------------------
interface exe_ctrl_stage_if #(
    parameter int DATA_W = 32
);
    logic [9:0]        ctrl_in;
    logic              ctrl_valid;
    logic [3:0]        dest_in;
    logic [DATA_W-1:0] store_data;
    logic              flush;
    logic [DATA_W-1:0] alu_result;
    logic [3:0]        alu_flags;
    logic [3:0]        ex_exe_cmd;
    logic              stall;
    logic              mem_req;
    logic              mem_we;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic              wb_en;
    logic [3:0]        wb_dest;
    logic [DATA_W-1:0] wb_value;
    logic              branch_taken;
    logic [3:0]        status;
    logic              mem_err;

    modport slave (
        input  ctrl_in, ctrl_valid, dest_in, store_data, flush,
        input  alu_result, alu_flags, mem_ack, mem_rdata,
        output ex_exe_cmd, stall, mem_req, mem_we, mem_addr, mem_wdata,
        output wb_en, wb_dest, wb_value, branch_taken, status, mem_err
    );

    modport master (
        output ctrl_in, ctrl_valid, dest_in, store_data, flush,
        output alu_result, alu_flags, mem_ack, mem_rdata,
        input  ex_exe_cmd, stall, mem_req, mem_we, mem_addr, mem_wdata,
        input  wb_en, wb_dest, wb_value, branch_taken, status, mem_err
    );
endinterface

// File: rtl/exe_ctrl_stage.sv
// ---------------------------------------------------------------------------
// exe_ctrl_stage
// Holds one decoded instruction, drives the ALU command, sequences a
// req/ack data-memory access for loads/stores, updates NZCV and issues a
// one-cycle writeback or branch pulse. Stalls the front end while busy.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    exe_ctrl_stage_if.slave (see interface file for signal list)
// Parameters:
//   DATA_W          datapath width
//   TIMEOUT_CYCLES  memory watchdog limit (only with MEM_TIMEOUT_EN)
// Optional feature:
//   `define MEM_TIMEOUT_EN to add the memory watchdog; otherwise MEM waits
//   indefinitely and mem_err is tied low.
// ---------------------------------------------------------------------------
module exe_ctrl_stage #(
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    exe_ctrl_stage_if.slave        bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MEM  = 2'd2,
        WB   = 2'd3
    } state_t;

    state_t            r_state;
    logic              r_s;
    logic              r_b;
    logic [3:0]        r_cmd;
    logic              r_memW;
    logic              r_isMem;
    logic              r_wbReq;
    logic [3:0]        r_dest;
    logic [DATA_W-1:0] r_store;
    logic              r_memReq;
    logic              r_memWe;
    logic [DATA_W-1:0] r_memAddr;
    logic [DATA_W-1:0] r_memWdata;
    logic              r_wbEn;
    logic [3:0]        r_wbDest;
    logic [DATA_W-1:0] r_wbValue;
    logic              r_branch;
    logic [3:0]        r_status;

    logic              w_accept;

`ifdef MEM_TIMEOUT_EN
    localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0]        r_wdog;
    logic              r_memErr;
`endif

    // A new instruction may only enter when the stage is empty or finishing
    // its writeback; flush suppresses capture.
    assign w_accept = bus.ctrl_valid && !bus.flush &&
                      ((r_state == IDLE) || (r_state == WB));

    // Single FSM block: all outputs except stall/ex_exe_cmd are registered
    // here. Strobes default low so wb_en, branch_taken and mem_err are
    // single-cycle pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_s        <= 1'b0;
            r_b        <= 1'b0;
            r_cmd      <= '0;
            r_memW     <= 1'b0;
            r_isMem    <= 1'b0;
            r_wbReq    <= 1'b0;
            r_dest     <= '0;
            r_store    <= '0;
            r_memReq   <= 1'b0;
            r_memWe    <= 1'b0;
            r_memAddr  <= '0;
            r_memWdata <= '0;
            r_wbEn     <= 1'b0;
            r_wbDest   <= '0;
            r_wbValue  <= '0;
            r_branch   <= 1'b0;
            r_status   <= '0;
`ifdef MEM_TIMEOUT_EN
            r_wdog     <= '0;
            r_memErr   <= 1'b0;
`endif
        end else begin
            r_wbEn   <= 1'b0;
            r_branch <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            r_memErr <= 1'b0;
            r_wdog   <= '0;
`endif
            if (bus.flush) begin
                // Kill the held instruction; any ack in this cycle is dropped.
                r_state  <= IDLE;
                r_memReq <= 1'b0;
                r_memWe  <= 1'b0;
            end else begin
                case (r_state)
                    IDLE, WB: begin
                        if (w_accept) begin
                            r_s     <= bus.ctrl_in[9];
                            r_b     <= bus.ctrl_in[8];
                            r_cmd   <= bus.ctrl_in[7:4];
                            r_memW  <= bus.ctrl_in[3];
                            r_isMem <= bus.ctrl_in[3] | bus.ctrl_in[2];
                            r_wbReq <= bus.ctrl_in[0];
                            r_dest  <= bus.dest_in;
                            r_store <= bus.store_data;
                            r_state <= EXEC;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                    EXEC: begin
                        if (r_isMem) begin
                            // Memory ops never touch status, even with S set.
                            r_memAddr  <= bus.alu_result;
                            r_memWdata <= r_store;
                            r_memReq   <= 1'b1;
                            r_memWe    <= r_memW;
                            r_state    <= MEM;
                        end else begin
                            r_wbValue <= bus.alu_result;
                            r_wbDest  <= r_dest;
                            r_wbEn    <= r_wbReq & ~r_b;
                            r_branch  <= r_b;
                            if (r_s) begin
                                r_status <= bus.alu_flags;
                            end
                            r_state   <= WB;
                        end
                    end
                    MEM: begin
                        if (bus.mem_ack) begin
                            // With both enables set the op is a store, so
                            // MEM_W_EN alone decides load vs store here.
                            r_memReq <= 1'b0;
                            r_memWe  <= 1'b0;
                            if (!r_memW) begin
                                r_wbValue <= bus.mem_rdata;
                            end
                            r_wbDest <= r_dest;
                            r_wbEn   <= r_wbReq & ~r_b & ~r_memW;
                            r_branch <= r_b;
                            r_state  <= WB;
                        end
`ifdef MEM_TIMEOUT_EN
                        else if (r_wdog == WDOG_LAST) begin
                            r_memReq <= 1'b0;
                            r_memWe  <= 1'b0;
                            r_memErr <= 1'b1;
                            r_state  <= IDLE;
                        end else begin
                            r_wdog <= r_wdog + 8'd1;
                        end
`endif
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign bus.stall        = (r_state == EXEC) || (r_state == MEM);
    assign bus.ex_exe_cmd   = (r_state == EXEC) ? r_cmd : 4'd0;
    assign bus.mem_req      = r_memReq;
    assign bus.mem_we       = r_memWe;
    assign bus.mem_addr     = r_memAddr;
    assign bus.mem_wdata    = r_memWdata;
    assign bus.wb_en        = r_wbEn;
    assign bus.wb_dest      = r_wbDest;
    assign bus.wb_value     = r_wbValue;
    assign bus.branch_taken = r_branch;
    assign bus.status       = r_status;
`ifdef MEM_TIMEOUT_EN
    assign bus.mem_err      = r_memErr;
`else
    assign bus.mem_err      = 1'b0;
`endif

endmodule
